// File: rtl/pcie_ss_axis_arb_pkg.sv
// rtl/pcie_ss_axis_arb_pkg.sv - arbiter state type and round-robin pick helper
package pcie_ss_axis_arb_pkg;

  localparam int unsigned ARB_MAX_PORTS = 8;
  localparam int unsigned ARB_MAX_PTR_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic                     found;
    logic [ARB_MAX_PTR_W-1:0] idx;
  } t_rr_pick;

  // Search begins one past last_ptr so the previous winner has lowest priority.
  function automatic t_rr_pick rr_pick(input logic [ARB_MAX_PORTS-1:0] valid,
                                       input logic [ARB_MAX_PTR_W-1:0] last_ptr,
                                       input int unsigned              num_ports);
    t_rr_pick    r;
    int unsigned p;
    r = '0;
    for (int unsigned k = 1; k <= ARB_MAX_PORTS; k++) begin
      p = ({29'd0, last_ptr} + k) % num_ports;
      if (k <= num_ports && !r.found && valid[p[ARB_MAX_PTR_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = p[ARB_MAX_PTR_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_ss_axis_pipe_reg.sv
// rtl/pcie_ss_axis_pipe_reg.sv - single-stage full-throughput AXI-S register slice
module pcie_ss_axis_pipe_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [USER_WIDTH-1:0]   in_tuser,
  input  logic                    in_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic [DATA_WIDTH-1:0]   out_tdata,
  output logic [DATA_WIDTH/8-1:0] out_tkeep,
  output logic [USER_WIDTH-1:0]   out_tuser,
  output logic                    out_tlast
);

  assign in_tready = !out_tvalid || out_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tuser  <= '0;
      out_tlast  <= 1'b0;
    end else if (in_tready) begin
      out_tvalid <= in_tvalid;
      if (in_tvalid) begin
        out_tdata <= in_tdata;
        out_tkeep <= in_tkeep;
        out_tuser <= in_tuser;
        out_tlast <= in_tlast;
      end
    end
  end

endmodule

// File: rtl/pcie_ss_axis_tlp_arb.sv
// rtl/pcie_ss_axis_tlp_arb.sv - packet-granular round-robin TX arbiter; option PCIE_SS_AXIS_TLP_ARB_STATS_EN
// adds per-port tlast counters (pkt_cnt) with a synchronous stats_clr.
module pcie_ss_axis_tlp_arb
  import pcie_ss_axis_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 512,
  parameter  int USER_WIDTH = 10,
  localparam int PTR_W      = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              in_tvalid,
  output logic [NUM_PORTS-1:0]              in_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]   in_tuser,
  input  logic [NUM_PORTS-1:0]              in_tlast,
  output logic                              out_tvalid,
  input  logic                              out_tready,
  output logic [DATA_WIDTH-1:0]             out_tdata,
  output logic [DATA_WIDTH/8-1:0]           out_tkeep,
  output logic [USER_WIDTH-1:0]             out_tuser,
  output logic                              out_tlast,
  output logic [PTR_W-1:0]                  cur_grant,
  output logic                              busy
`ifdef PCIE_SS_AXIS_TLP_ARB_STATS_EN
  ,
  input  logic                              stats_clr,
  output logic [NUM_PORTS*16-1:0]           pkt_cnt
`endif
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  t_arb_state                 state;
  logic [PTR_W-1:0]           grant_q;
  logic [PTR_W-1:0]           last_ptr;
  logic [ARB_MAX_PORTS-1:0]   valid_ext;
  t_rr_pick                   pick;
  logic [ARB_MAX_PTR_W-1:0]   sel;
  logic                       sel_live;
  logic                       sel_valid;
  logic                       sel_last;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [KEEP_WIDTH-1:0]      sel_keep;
  logic [USER_WIDTH-1:0]      sel_user;
  logic                       adv;
  logic                       accept;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_PORTS-1:0] = in_tvalid;
    pick = rr_pick(valid_ext, ARB_MAX_PTR_W'(last_ptr), NUM_PORTS);
  end

  // A locked port keeps the output even while its valid is low, so other ports cannot cut in.
  always_comb begin
    sel_live = (state == ARB_LOCKED) || pick.found;
    sel      = (state == ARB_LOCKED) ? ARB_MAX_PTR_W'(grant_q) : pick.idx;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_tready[i] = sel_live && adv && (sel == ARB_MAX_PTR_W'(i));
      if (sel == ARB_MAX_PTR_W'(i)) begin
        sel_valid = sel_live && in_tvalid[i];
        sel_last  = in_tlast[i];
        sel_data  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = in_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = in_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  assign accept = sel_valid && adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant_q  <= '0;
      last_ptr <= PTR_W'(NUM_PORTS - 1);
    end else if (accept) begin
      if (state == ARB_IDLE) begin
        last_ptr <= sel[PTR_W-1:0];
        if (!sel_last) begin
          state   <= ARB_LOCKED;
          grant_q <= sel[PTR_W-1:0];
        end
      end else if (sel_last) begin
        state <= ARB_IDLE;
      end
    end
  end

  assign busy      = (state == ARB_LOCKED);
  assign cur_grant = grant_q;

  pcie_ss_axis_pipe_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_tvalid  (sel_valid),
    .in_tready  (adv),
    .in_tdata   (sel_data),
    .in_tkeep   (sel_keep),
    .in_tuser   (sel_user),
    .in_tlast   (sel_last),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tuser  (out_tuser),
    .out_tlast  (out_tlast)
  );

`ifdef PCIE_SS_AXIS_TLP_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rst || stats_clr) begin
        cnt_q[i] <= '0;
      end else if (accept && sel_last && (sel == ARB_MAX_PTR_W'(i))) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      pkt_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_pcie_ss_axis_tlp_arb.sv
// tb/tb_pcie_ss_axis_tlp_arb.sv - randomized bench with packet-level reference model for the TLP arbiter
module tb_pcie_ss_axis_tlp_arb;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int UW = 10;
  localparam int KW = DW / 8;
  localparam int PW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        in_tvalid;
  logic [NP-1:0]        in_tready;
  logic [NP*DW-1:0]     in_tdata;
  logic [NP*KW-1:0]     in_tkeep;
  logic [NP*UW-1:0]     in_tuser;
  logic [NP-1:0]        in_tlast;
  logic                 out_tvalid;
  logic                 out_tready;
  logic [DW-1:0]        out_tdata;
  logic [KW-1:0]        out_tkeep;
  logic [UW-1:0]        out_tuser;
  logic                 out_tlast;
  logic [PW-1:0]        cur_grant;
  logic                 busy;
`ifdef PCIE_SS_AXIS_TLP_ARB_STATS_EN
  logic                 stats_clr;
  logic [NP*16-1:0]     pkt_cnt;
`endif

  always #5 clk = ~clk;

  pcie_ss_axis_tlp_arb #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tuser   (in_tuser),
    .in_tlast   (in_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tuser  (out_tuser),
    .out_tlast  (out_tlast),
    .cur_grant  (cur_grant),
    .busy       (busy)
`ifdef PCIE_SS_AXIS_TLP_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .pkt_cnt    (pkt_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t pq [NP][$];
  bit    rdy_pat[$];
  int    got[$];
  int    hs_cyc[$];
  int    errors = 0;
  int    checks = 0;
  int    cycle  = 0;
  int    seq    = 0;
  int    dens     = 100;
  int    rdy_dens = 100;

  // Reference model: owning port (-1 = none), last packet winner, held output beat.
  int    owner;
  int    ptr;
  bit    mv;
  beat_t mbeat;
  int    exp_cnt [NP];

  task automatic model_reset();
    owner = -1;
    ptr   = NP - 1;
    mv    = 1'b0;
    mbeat = '0;
    for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
  endtask

  task automatic add_pkt(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {4'(port), 28'(seq), 32'($urandom())};
      b.keep = KW'($urandom());
      b.user = UW'($urandom());
      b.last = (i == len - 1);
      seq++;
      pq[port].push_back(b);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() != 0) begin
        in_tvalid[p]            = ($urandom_range(99) < dens);
        in_tdata[p*DW +: DW]    = pq[p][0].data;
        in_tkeep[p*KW +: KW]    = pq[p][0].keep;
        in_tuser[p*UW +: UW]    = pq[p][0].user;
        in_tlast[p]             = pq[p][0].last;
      end else begin
        in_tvalid[p]            = 1'b0;
        in_tdata[p*DW +: DW]    = '0;
        in_tkeep[p*KW +: KW]    = '0;
        in_tuser[p*UW +: UW]    = '0;
        in_tlast[p]             = 1'b0;
      end
    end
    if (rdy_pat.size() != 0) out_tready = rdy_pat.pop_front();
    else                     out_tready = ($urandom_range(99) < rdy_dens);
  endtask

  task automatic step();
    logic [NP-1:0] er;
    int            g;
    bit            adv;
    bit            acc;
    @(negedge clk);
    adv = !mv || out_tready;
    g   = -1;
    er  = '0;
    if (owner >= 0) g = owner;
    else begin
      for (int k = 1; k <= NP; k++)
        if (g < 0 && in_tvalid[(ptr + k) % NP]) g = (ptr + k) % NP;
    end
    if (g >= 0 && adv) er[g] = 1'b1;
    checks++;
    if (in_tready !== er) begin
      errors++;
      $display("FAIL in_tready cyc=%0d actual=%b expected=%b", cycle, in_tready, er);
    end
    checks++;
    if (out_tvalid !== mv) begin
      errors++;
      $display("FAIL out_tvalid cyc=%0d actual=%b expected=%b", cycle, out_tvalid, mv);
    end
    if (mv) begin
      checks++;
      if ({out_tdata, out_tkeep, out_tuser, out_tlast} !== mbeat) begin
        errors++;
        $display("FAIL out_beat cyc=%0d actual=%h/%h/%h/%b expected=%h/%h/%h/%b", cycle,
                 out_tdata, out_tkeep, out_tuser, out_tlast, mbeat.data, mbeat.keep, mbeat.user, mbeat.last);
      end
    end
    checks++;
    if (busy !== (owner >= 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d actual=%b expected=%b", cycle, busy, owner >= 0);
    end
    if (owner >= 0) begin
      checks++;
      if (cur_grant !== PW'(owner)) begin
        errors++;
        $display("FAIL cur_grant cyc=%0d actual=%0d expected=%0d", cycle, cur_grant, owner);
      end
    end
    if (out_tvalid === 1'b1 && out_tready) begin
      got.push_back(int'(out_tdata[DW-1 -: 4]));
      hs_cyc.push_back(cycle);
    end
    acc = (g >= 0) && adv && in_tvalid[g] && !rst;
`ifdef PCIE_SS_AXIS_TLP_ARB_STATS_EN
    if (stats_clr) begin
      for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
    end else if (acc && pq[g][0].last) begin
      exp_cnt[g] = (exp_cnt[g] + 1) % 65536;
    end
`endif
    if (rst) model_reset();
    else begin
      if (adv) begin
        mv = acc;
        if (acc) mbeat = pq[g][0];
      end
      if (acc) begin
        if (owner < 0) ptr = g;
        owner = pq[g][0].last ? -1 : g;
        void'(pq[g].pop_front());
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    drive();
  endtask

  function automatic bit pending();
    bit r;
    r = mv;
    for (int p = 0; p < NP; p++) if (pq[p].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d cycles expected=drained", n);
    end
    step();
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) pq[p].delete();
    rdy_pat.delete();
    dens     = 100;
    rdy_dens = 100;
    drive();
    rst = 1'b1;
    step();
    rst = 1'b0;
    got.delete();
    hs_cyc.delete();
  endtask

  task automatic check_order(input string name, input int exp[$]);
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_count actual=%0d expected=%0d", name, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] != exp[i]) begin
          errors++;
          $display("FAIL %s_port[%0d] actual=%0d expected=%0d", name, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_tvalid !== 1'b0 || out_tlast !== 1'b0 || out_tdata !== '0 || out_tkeep !== '0 || out_tuser !== '0) begin
      errors++;
      $display("FAIL reset_out actual=%b/%b/%h expected=0/0/0", out_tvalid, out_tlast, out_tdata);
    end
    checks++;
    if (busy !== 1'b0 || cur_grant !== '0 || in_tready !== '0) begin
      errors++;
      $display("FAIL reset_ctrl actual=%b/%0d/%b expected=0/0/0", busy, cur_grant, in_tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rr_order();
    int exp[$];
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) begin
        add_pkt(p, 1);
        exp.push_back(p);
      end
    drive();
    drain(100);
    check_order("rr", exp);
    checks++;
    if (hs_cyc.size() != 12 || hs_cyc[hs_cyc.size()-1] - hs_cyc[0] != 11) begin
      errors++;
      $display("FAIL rr_throughput actual=%0d beats expected=12 contiguous", hs_cyc.size());
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    add_pkt(1, 3);
    drive();
    step();
    add_pkt(2, 1);
    drive();
    drain(100);
    check_order("lock", '{1, 1, 1, 2});
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rdy_pat.push_back(1'b1);
      rdy_pat.push_back(1'b0);
    end
    add_pkt(0, 4);
    drive();
    drain(100);
    check_order("stall", '{0, 0, 0, 0});
  endtask

  task automatic test_wrap();
    do_reset();
    add_pkt(3, 2);
    drive();
    step();
    add_pkt(0, 1);
    add_pkt(3, 1);
    drive();
    drain(100);
    check_order("wrap", '{3, 3, 0, 3});
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_pkt(2, 5);
    drive();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) pq[p].delete();
    drive();
    @(negedge clk);
    checks++;
    if (out_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid actual=%b/%b expected=0/0", out_tvalid, busy);
    end
    @(posedge clk);
    #1;
    got.delete();
    add_pkt(2, 1);
    add_pkt(0, 1);
    drive();
    drain(100);
    check_order("reset_mid", '{0, 2});
  endtask

  task automatic test_random();
    int total;
    do_reset();
    total = 0;
    for (int i = 0; i < 150; i++) begin
      int len;
      len = $urandom_range(1, 5);
      add_pkt($urandom_range(NP - 1), len);
      total += len;
    end
    dens     = 60;
    rdy_dens = 70;
    drive();
    drain(5000);
    checks++;
    if (got.size() != total) begin
      errors++;
      $display("FAIL random_beats actual=%0d expected=%0d", got.size(), total);
    end
    dens     = 100;
    rdy_dens = 100;
  endtask

`ifdef PCIE_SS_AXIS_TLP_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 70000; i++) add_pkt(1, 1);
    drive();
    drain(80000);
    checks++;
    if (pkt_cnt[16 +: 16] !== 16'd4464 || pkt_cnt[16 +: 16] !== 16'(exp_cnt[1])) begin
      errors++;
      $display("FAIL stats_wrap actual=%0d expected=4464", pkt_cnt[16 +: 16]);
    end
    checks++;
    if (pkt_cnt[0 +: 16] !== 16'd0 || pkt_cnt[32 +: 32] !== 32'd0) begin
      errors++;
      $display("FAIL stats_other actual=%h expected=0", pkt_cnt);
    end
    add_pkt(1, 1);
    drive();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    drain(20);
    checks++;
    if (pkt_cnt[16 +: 16] !== 16'd0) begin
      errors++;
      $display("FAIL stats_clr actual=%0d expected=0", pkt_cnt[16 +: 16]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_tvalid = '0;
    in_tdata  = '0;
    in_tkeep  = '0;
    in_tuser  = '0;
    in_tlast  = '0;
    out_tready = 1'b0;
`ifdef PCIE_SS_AXIS_TLP_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_rr_order();
    test_lock_hold();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef PCIE_SS_AXIS_TLP_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_ss_axis_tlp_arb.md
Name: pcie_ss_axis_tlp_arb

Overview:
- Packet-granular round-robin arbiter that shares one PCIe SS AXI-S TX stream between NUM_PORTS requesters.
- Sits upstream of the TX merge / in-band-to-side-band stages. Once a port wins, it holds the output until its tlast beat is accepted, so TLPs never interleave.
- The output is a single registered pipeline stage and must sustain full throughput.

Parameters:
- NUM_PORTS, 4, number of input requesters (2..8).
- DATA_WIDTH, 512, tdata width in bits (256/512/1024).
- USER_WIDTH, 10, tuser width per port.
- PTR_W, $clog2(NUM_PORTS), derived localparam; grant index width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_tvalid  in  NUM_PORTS  per-port valid.
- in_tready  out  NUM_PORTS  per-port ready.
- in_tdata  in  NUM_PORTS*DATA_WIDTH  port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- in_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- in_tuser  in  NUM_PORTS*USER_WIDTH  per-port tuser.
- in_tlast  in  NUM_PORTS  per-port end of packet.
- out_tvalid  out  1  output valid (registered).
- out_tready  in  1  downstream ready.
- out_tdata  out  DATA_WIDTH  registered data.
- out_tkeep  out  DATA_WIDTH/8  registered keep.
- out_tuser  out  USER_WIDTH  registered tuser.
- out_tlast  out  1  registered tlast.
- cur_grant  out  PTR_W  port currently owning the output (valid when busy).
- busy  out  1  a packet is mid-flight (locked).

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - out_tvalid=0, out_tlast=0, out_tdata/tkeep/tuser=0.
  - busy=0, cur_grant=0.
  - last_ptr=NUM_PORTS-1, so port 0 has first priority.
- Pipeline register:
  - adv = !out_tvalid || out_tready.
  - An input beat is accepted when in_tvalid[g] && in_tready[g]; it appears on out_* the next cycle.
  - Latency is exactly 1 cycle. Back-to-back beats run with no bubbles.
- State machine, two states:
  - IDLE: the combinational winner g is the first port with in_tvalid set, searching from last_ptr+1 modulo NUM_PORTS. in_tready[g]=adv; all other in_tready=0.
    - On acceptance with in_tlast=0: go to LOCKED, cur_grant<=g.
    - On acceptance with in_tlast=1 (single-beat TLP): stay in IDLE.
    - On every IDLE acceptance: last_ptr<=g.
  - LOCKED: in_tready[cur_grant]=adv; all others 0. Other ports' valids are ignored. Go to IDLE when a beat with in_tlast=1 is accepted. busy=1 only in LOCKED.
- Arbitration is decided at start-of-packet only; the pointer advances per packet, not per beat.
- No valid input in IDLE: all in_tready=0, and out_tvalid clears once the held beat drains.
- Downstream stall (out_tready=0 with out_tvalid=1): all in_tready=0; out_* hold stable (AXI-S rule).
- An input dropping tvalid mid-packet while LOCKED: the lock holds and the output bubbles; no other port is granted.
- Simultaneous tlast acceptance on port g and new valids: the next IDLE cycle starts its search from g+1.
- Wrap-around: the search from port NUM_PORTS-1 continues at port 0.
- Reset mid-packet: the lock and output are discarded immediately; the partial TLP is not completed.

Optional Feature:
- Macro: PCIE_SS_AXIS_TLP_ARB_STATS_EN.
- Defined:
  - Adds output pkt_cnt[NUM_PORTS*16], a per-port 16-bit count of accepted tlast beats.
  - Counters wrap at 0xFFFF->0 and reset to 0.
  - Adds input stats_clr; a synchronous clear that takes priority over increment in the same cycle.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pcie_ss_axis_arb_pkg holds:
  - typedef t_arb_state {ARB_IDLE, ARB_LOCKED};
  - function rr_pick(valid, last_ptr) returning the winner index and a found flag.
- One natural sub-module: pcie_ss_axis_pipe_reg, the 1-stage AXI-S register carrying data/keep/user/last. It is reused elsewhere in the components directory.

Test Plan:
- All 4 ports continuously valid with 1-beat TLPs and out_tready=1 -> output port order 0,1,2,3,0,1,... with one beat every cycle.
- Port 1 sends a 3-beat TLP while port 2 is valid from cycle 1 -> all 3 port-1 beats are contiguous, then port 2. in_tready[2]=0 until port 1's tlast is accepted.
- out_tready toggles 1,0,1,0 during a 4-beat TLP on port 0 -> out_* stable while stalled, 4 beats delivered in order, no drops or duplicates, busy falls after the 4th beat.
- Only port 3 valid, then ports 0 and 3 both valid -> after port 3's packet, port 0 wins (wrap-around), then port 3.
- Assert rst for 1 cycle mid-way through a 5-beat TLP on port 2 -> next cycle out_tvalid=0, busy=0. The subsequent arbitration grants port 0 first if valid.
- With STATS_EN: 70000 single-beat TLPs on port 1 -> pkt_cnt[1]=70000 mod 65536=4464. Pulse stats_clr during an accept -> the count reads 0.
